// File: rtl/fb_arb_pkg.sv
// Shared definitions for the frame-buffer write arbiter: requester indices,
// FSM state encoding, the PLAY game-state code and the default buffer size.
package fb_arb_pkg;

    localparam int NUM_REQ  = 3;
    localparam int REQ_CLR  = 0;
    localparam int REQ_BLUE = 1;
    localparam int REQ_RED  = 2;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;

    localparam logic [2:0]        GAME_PLAY    = 3'b010;
    localparam logic [ADDR_W-1:0] FB_WORDS_DEF = 20'd614400;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

    // True when a one-hot grant names one of the two trail requesters.
    function automatic logic is_trail(input logic [NUM_REQ-1:0] oh);
        return oh[REQ_BLUE] | oh[REQ_RED];
    endfunction

endpackage

// File: rtl/fb_rr_pick.sv
// Combinational winner selection. The clear engine has strict priority;
// blue and red alternate through a pointer that names the last trail winner.
module fb_rr_pick
    import fb_arb_pkg::*;
(
    input  logic [2:0] elig,
    input  logic       ptr_red,
    output logic [2:0] win
);

    // Priority: clear first, then the trail that did not win last time.
    always_comb begin
        win = 3'b000;
        if (elig[REQ_CLR]) begin
            win[REQ_CLR] = 1'b1;
        end else if (elig[REQ_BLUE] && elig[REQ_RED]) begin
            if (ptr_red) win[REQ_BLUE] = 1'b1;
            else         win[REQ_RED]  = 1'b1;
        end else if (elig[REQ_BLUE]) begin
            win[REQ_BLUE] = 1'b1;
        end else if (elig[REQ_RED]) begin
            win[REQ_RED] = 1'b1;
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// Frame-buffer write arbiter: grants one of three requesters (clear engine,
// blue trail, red trail) a burst of up to MAX_BURST words and forwards each
// transferred word to a registered frame-buffer write port. A RELEASE cycle
// always separates two grants.
// Optional build macro FB_ARB_BOUNDS_EN: drop writes at or beyond FB_WORDS
// and raise a sticky bounds_err.
module fb_write_arbiter
    import fb_arb_pkg::*;
#(
    parameter int          MAX_BURST = 16,
    parameter logic [19:0] FB_WORDS  = FB_WORDS_DEF
)(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [2:0]  Game_State,
    input  logic [2:0]  req,
    input  logic [2:0]  req_last,
    input  logic [59:0] req_addr,
    input  logic [47:0] req_data,
    output logic [2:0]  grant,
    output logic        fb_we,
    output logic [19:0] fb_addr,
    output logic [15:0] fb_data,
    output logic        busy,
    output logic        bounds_err
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    arb_state_t       state, state_nxt;
    logic [2:0]       grant_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic             ptr_red, ptr_nxt;

    logic             play;
    logic [2:0]       elig;
    logic [2:0]       win;
    logic             g_req, g_last, abort, xfer, done, in_range, wr;
    logic [19:0]      sel_addr;
    logic [15:0]      sel_data;

    assign play = (Game_State == GAME_PLAY);

    // Trails may only compete while the game is in PLAY.
    assign elig = {req[REQ_RED] & play, req[REQ_BLUE] & play, req[REQ_CLR]};

    fb_rr_pick u_pick (
        .elig    (elig),
        .ptr_red (ptr_red),
        .win     (win)
    );

    // One-hot AND-OR mux of the granted requester's address, data and last.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = sel_addr | req_addr[ADDR_W*i +: ADDR_W];
                sel_data = sel_data | req_data[DATA_W*i +: DATA_W];
            end
        end
    end

    assign g_req   = |(req & grant);
    assign g_last  = |(req_last & req & grant);
    assign abort   = is_trail(grant) && !play;
    assign xfer    = (state == ST_GRANT) && g_req && !abort;
    assign cnt_inc = cnt + CNT_W'(1);
    assign done    = (xfer && (g_last || cnt_inc == CNT_MAX)) || !g_req || abort;

`ifdef FB_ARB_BOUNDS_EN
    assign in_range = (sel_addr < FB_WORDS);
`else
    assign in_range = 1'b1;
`endif

    // A transfer always counts toward the burst; only in-range words are written.
    assign wr = xfer && in_range;

    // Next-state, next-grant, burst counter and round-robin pointer.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        cnt_nxt   = cnt;
        ptr_nxt   = ptr_red;
        unique case (state)
            ST_IDLE: begin
                if (|elig) begin
                    state_nxt = ST_GRANT;
                    grant_nxt = win;
                    cnt_nxt   = '0;
                    if (win[REQ_BLUE]) ptr_nxt = 1'b0;
                    if (win[REQ_RED])  ptr_nxt = 1'b1;
                end
            end
            ST_GRANT: begin
                if (xfer) cnt_nxt = cnt_inc;
                if (done) begin
                    state_nxt = ST_RELEASE;
                    grant_nxt = 3'b000;
                end
            end
            ST_RELEASE: begin
                state_nxt = ST_IDLE;
                grant_nxt = 3'b000;
            end
            default: begin
                state_nxt = ST_IDLE;
                grant_nxt = 3'b000;
            end
        endcase
    end

    // Control state; the pointer resets to red so blue wins the first tie.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= ST_IDLE;
            grant   <= 3'b000;
            cnt     <= '0;
            ptr_red <= 1'b1;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            cnt     <= cnt_nxt;
            ptr_red <= ptr_nxt;
        end
    end

    // Registered write port; address/data only move when a word is written.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fb_we   <= 1'b0;
            fb_addr <= '0;
            fb_data <= '0;
        end else begin
            fb_we <= wr;
            if (wr) begin
                fb_addr <= sel_addr;
                fb_data <= sel_data;
            end
        end
    end

`ifdef FB_ARB_BOUNDS_EN
    // Sticky flag for any transfer that targeted an address past the buffer.
    always_ff @(posedge Clk) begin
        if (Reset)                  bounds_err <= 1'b0;
        else if (xfer && !in_range) bounds_err <= 1'b1;
    end
`else
    assign bounds_err = 1'b0;
`endif

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter. Expected frame-buffer writes are queued
// as words are offered and checked when fb_we appears; cycle-level grant and
// busy behaviour is checked inline.
module tb_fb_write_arbiter;
    import fb_arb_pkg::*;

    logic        Clk;
    logic        Reset;
    logic [2:0]  Game_State;
    logic [2:0]  req;
    logic [2:0]  req_last;
    logic [59:0] req_addr;
    logic [47:0] req_data;
    logic [2:0]  grant;
    logic        fb_we;
    logic [19:0] fb_addr;
    logic [15:0] fb_data;
    logic        busy;
    logic        bounds_err;

    int vectors    = 0;
    int miscompares = 0;
    logic [35:0] exp_q[$];
    logic [35:0] exp_w;

    fb_write_arbiter #(.MAX_BURST(16)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Game_State (Game_State),
        .req        (req),
        .req_last   (req_last),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .grant      (grant),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .busy       (busy),
        .bounds_err (bounds_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic cyc;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input int i, input logic on, input logic [19:0] a,
                       input logic [15:0] d, input logic last);
        req[i]               = on;
        req_last[i]          = last;
        req_addr[20*i +: 20] = a;
        req_data[16*i +: 16] = d;
    endtask

    task automatic push(input logic [19:0] a, input logic [15:0] d);
        exp_q.push_back({a, d});
    endtask

    // Scoreboard: every observed write must match the oldest queued word.
    always @(negedge Clk) begin
        if (fb_we === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $error("FAIL wr_unexpected: observed %0h_%0h expected no write", fb_addr, fb_data);
            end else begin
                exp_w = exp_q.pop_front();
                assert ({fb_addr, fb_data} === exp_w) else begin
                    miscompares++;
                    $error("FAIL wr_data: observed %0h expected %0h", {fb_addr, fb_data}, exp_w);
                end
            end
        end
    end

    initial begin
        Reset = 1'b1; Game_State = 3'b000;
        req = '0; req_last = '0; req_addr = '0; req_data = '0;
        cyc; cyc;
        chk("rst_grant", 32'(grant), 0);
        chk("rst_we", 32'(fb_we), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_addr", 32'(fb_addr), 0);
        chk("rst_data", 32'(fb_data), 0);
        chk("rst_berr", 32'(bounds_err), 0);
        Reset = 1'b0; Game_State = GAME_PLAY;

        // Single 3-word blue burst.
        put(1, 1, 20'h00100, 16'hB000, 0); push(20'h00100, 16'hB000);
        cyc; chk("t1_grant", 32'(grant), 3'b010); chk("t1_busy", 32'(busy), 1); chk("t1_we0", 32'(fb_we), 0);
        cyc; chk("t1_we1", 32'(fb_we), 1);
        put(1, 1, 20'h00101, 16'hB001, 0); push(20'h00101, 16'hB001);
        cyc; chk("t1_we2", 32'(fb_we), 1);
        put(1, 1, 20'h00102, 16'hB002, 1); push(20'h00102, 16'hB002);
        cyc; chk("t1_we3", 32'(fb_we), 1); chk("t1_rel_grant", 32'(grant), 0); chk("t1_rel_busy", 32'(busy), 1);
        put(1, 0, 20'h0, 16'h0, 0);
        cyc; chk("t1_idle_we", 32'(fb_we), 0); chk("t1_idle_busy", 32'(busy), 0);

        // Clear beats blue when both rise together.
        put(0, 1, 20'h00200, 16'hC000, 1); put(1, 1, 20'h00300, 16'hB100, 1);
        push(20'h00200, 16'hC000); push(20'h00300, 16'hB100);
        cyc; chk("t2_grant_clr", 32'(grant), 3'b001);
        cyc; chk("t2_rel_grant", 32'(grant), 0); chk("t2_we", 32'(fb_we), 1);
        put(0, 0, 20'h0, 16'h0, 0);
        cyc; chk("t2_gap_grant", 32'(grant), 0); chk("t2_gap_busy", 32'(busy), 0);
        cyc; chk("t2_grant_blue", 32'(grant), 3'b010);
        cyc; chk("t2_we_blue", 32'(fb_we), 1); chk("t2_rel2", 32'(grant), 0);
        put(1, 0, 20'h0, 16'h0, 0);
        cyc; chk("t2_idle", 32'(busy), 0);

        // Red without last: forced release after 16 words, then re-grant.
        put(2, 1, 20'h01000, 16'hA000, 0); push(20'h01000, 16'hA000);
        cyc; chk("t3_grant", 32'(grant), 3'b100);
        for (int k = 0; k < 16; k++) begin
            cyc; chk("t3_we", 32'(fb_we), 1);
            if (k < 15) begin
                chk("t3_hold", 32'(grant), 3'b100);
                push(20'h01000 + 20'(k + 1), 16'hA000 + 16'(k + 1));
            end
            put(2, 1, 20'h01000 + 20'(k + 1), 16'hA000 + 16'(k + 1), 0);
        end
        chk("t3_rel_grant", 32'(grant), 0);
        cyc; chk("t3_gap_we", 32'(fb_we), 0); chk("t3_gap_busy", 32'(busy), 0);
        cyc; chk("t3_regrant", 32'(grant), 3'b100);
        put(2, 0, 20'h0, 16'h0, 0);
        cyc; chk("t3_drop_we", 32'(fb_we), 0); chk("t3_drop_grant", 32'(grant), 0);
        cyc; chk("t3_idle", 32'(busy), 0);

        // Game leaves PLAY mid-burst: that word is not written.
        put(1, 1, 20'h02000, 16'hB200, 0); push(20'h02000, 16'hB200);
        cyc; chk("t4_grant", 32'(grant), 3'b010);
        cyc; chk("t4_we", 32'(fb_we), 1);
        put(1, 1, 20'h02001, 16'hB201, 0); Game_State = 3'b001;
        cyc; chk("t4_abort_we", 32'(fb_we), 0); chk("t4_abort_grant", 32'(grant), 0);
        put(1, 0, 20'h0, 16'h0, 0); Game_State = GAME_PLAY;
        cyc; chk("t4_idle", 32'(busy), 0);

        // Reset during word 2 of a red burst.
        put(2, 1, 20'h03000, 16'hA100, 0); push(20'h03000, 16'hA100);
        cyc; chk("t5_grant", 32'(grant), 3'b100);
        cyc; chk("t5_we", 32'(fb_we), 1);
        put(2, 1, 20'h03001, 16'hA101, 0); Reset = 1'b1;
        cyc; chk("t5_rst_we", 32'(fb_we), 0); chk("t5_rst_grant", 32'(grant), 0);
        chk("t5_rst_busy", 32'(busy), 0); chk("t5_rst_addr", 32'(fb_addr), 0); chk("t5_rst_data", 32'(fb_data), 0);
        Reset = 1'b0; put(2, 0, 20'h0, 16'h0, 0);
        cyc; chk("t5_after_we", 32'(fb_we), 0);

        // Round robin with both trails held; reset pointer lets blue go first.
        put(1, 1, 20'h04000, 16'hB300, 1); put(2, 1, 20'h05000, 16'hA300, 1);
        for (int r = 0; r < 4; r++) begin
            if (r % 2 == 0) push(20'h04000, 16'hB300);
            else            push(20'h05000, 16'hA300);
        end
        for (int r = 0; r < 4; r++) begin
            cyc; chk("t6_grant", 32'(grant), (r % 2 == 0) ? 32'h2 : 32'h4);
            cyc; chk("t6_we", 32'(fb_we), 1); chk("t6_rel", 32'(grant), 0);
            if (r == 3) begin
                put(1, 0, 20'h0, 16'h0, 0); put(2, 0, 20'h0, 16'h0, 0);
            end
            cyc; chk("t6_gap", 32'(grant), 0); chk("t6_gap_busy", 32'(busy), 0);
        end

        // Address at the buffer limit, then the last valid address.
        put(0, 1, 20'd614400, 16'hC100, 1);
`ifndef FB_ARB_BOUNDS_EN
        push(20'd614400, 16'hC100);
`endif
        cyc; chk("t7_grant", 32'(grant), 3'b001);
        cyc;
`ifdef FB_ARB_BOUNDS_EN
        chk("t7_oob_we", 32'(fb_we), 0); chk("t7_berr", 32'(bounds_err), 1);
`else
        chk("t7_oob_we", 32'(fb_we), 1); chk("t7_berr", 32'(bounds_err), 0);
`endif
        put(0, 0, 20'h0, 16'h0, 0);
        cyc;
        put(0, 1, 20'd614399, 16'hC101, 1); push(20'd614399, 16'hC101);
        cyc; chk("t7_grant2", 32'(grant), 3'b001);
        cyc; chk("t7_we2", 32'(fb_we), 1);
`ifdef FB_ARB_BOUNDS_EN
        chk("t7_berr_sticky", 32'(bounds_err), 1);
`else
        chk("t7_berr_tied", 32'(bounds_err), 0);
`endif
        put(0, 0, 20'h0, 16'h0, 0);
        cyc;
        chk("sb_drained", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fb_write_arbiter.md
FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 16, maximum words transferred per grant.
REQ-002 Parameter FB_WORDS, default 20'd614400, number of addressable frame-buffer words.
REQ-003 Clk  in  1  system clock; Reset is synchronous to its rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 Game_State  in  3  game state; 3'b010 is PLAY.
REQ-006 req  in  3  request per requester; [0] clear engine, [1] blue trail, [2] red trail.
REQ-007 req_last  in  3  marks the final word of a burst, qualified by req.
REQ-008 req_addr  in  60  word address per requester, 20 bits each, index i at [20i+19:20i].
REQ-009 req_data  in  48  write data per requester, 16 bits each, index i at [16i+15:16i].
REQ-010 grant  out  3  one-hot grant, registered.
REQ-011 fb_we  out  1  frame-buffer write enable, registered.
REQ-012 fb_addr  out  20  frame-buffer write address, registered.
REQ-013 fb_data  out  16  frame-buffer write data, registered.
REQ-014 busy  out  1  high whenever the state is not IDLE.
REQ-015 bounds_err  out  1  sticky out-of-range flag (see REQ-030).

Function
REQ-016 States are IDLE, GRANT and RELEASE; the arbiter SHALL hold exactly one grant at a time.
REQ-017 Eligibility in IDLE:
- req[0] is always eligible.
- req[1] and req[2] are eligible only while Game_State == 3'b010.
REQ-018 Priority:
- Clear (index 0) has strict priority.
- Blue and red alternate by a round-robin pointer that names the last trail winner.
- If only one trail requester is eligible, it wins regardless of the pointer.
REQ-019 IDLE with an eligible request: next cycle goes to GRANT, sets grant[winner] and clears the burst counter. With no eligible request it stays in IDLE.
REQ-020 GRANT transfer: each cycle req[g] & grant[g] is high, one word transfers.
- fb_we=1, fb_addr=req_addr[g], fb_data=req_data[g] appear one cycle later.
- The burst counter increments.
REQ-021 GRANT goes to RELEASE after any of:
- a transfer with req_last[g]=1;
- the MAX_BURST-th transfer;
- req[g] low;
- g != 0 and Game_State != 3'b010. This transfer is suppressed and grant drops on the next edge.
REQ-022 RELEASE: grant=0, no transfer, next state is IDLE; this guarantees a one-cycle gap between grants.
REQ-023 The round-robin pointer updates on entry to GRANT only when a trail requester wins.
REQ-024 fb_we SHALL be 0 in every cycle not following a transfer; fb_addr and fb_data hold their last values when fb_we=0.
REQ-025 The burst counter is $clog2(MAX_BURST+1) bits wide and never wraps.
REQ-026 Requests asserted while another requester holds the grant SHALL wait; they are never dropped by the arbiter.

Reset
REQ-027 On Reset, all of the following take effect on the next edge, including mid-burst; an in-flight word SHALL NOT be written:
- state=IDLE; grant=0; fb_we=0; fb_addr=0; fb_data=0;
- busy=0; bounds_err=0; counter=0; round-robin pointer names red, so blue wins the first tie.

Configuration
REQ-028 Macro FB_ARB_BOUNDS_EN selects address range checking.
REQ-029 Without FB_ARB_BOUNDS_EN, every transfer is written and bounds_err is tied 0.
REQ-030 With FB_ARB_BOUNDS_EN, a transfer whose address is >= FB_WORDS is counted but not written (fb_we stays 0), and bounds_err is set and held until Reset.

Structure
REQ-031 Package fb_arb_pkg SHALL hold:
- requester indices REQ_CLR=0, REQ_BLUE=1, REQ_RED=2;
- the state enum;
- GAME_PLAY=3'b010;
- the FB_WORDS default.
REQ-032 Sub-module fb_rr_pick SHALL be purely combinational. It takes the eligible mask and the pointer and returns the one-hot winner.

Verification
REQ-033 Single request: req[1] with a 3-word burst, last on word 3, PLAY. Required:
- grant[1] one cycle after req;
- fb_we high for 3 cycles, each word one cycle after its transfer;
- one RELEASE cycle, then IDLE.
REQ-034 Clear priority: req[0] and req[1] rise together. grant[0] wins. grant[1] rises only after the clear burst's RELEASE cycle.
REQ-035 Round robin: req[1] and req[2] are held continuously with 1-word bursts. Grants alternate 1,2,1,2 with one idle gap between each.
REQ-036 Forced release: req[2] with MAX_BURST=16 and no last. Exactly 16 writes occur, then RELEASE, then a re-grant if still requested. Separately, Game_State leaves 3'b010 mid-burst; the word in that cycle is not written.
REQ-037 Reset and bounds:
- Reset asserted during word 2 of a burst: fb_we=0 and grant=0 on the next edge, with no further writes.
- With FB_ARB_BOUNDS_EN, a write to address 20'd614400 produces no fb_we and a sticky bounds_err=1.
